// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the round-based game sequencer.
//   game_state_t     : 3-bit FSM state encoding (IDLE..GAME_OVER)
//   DEPTH_W, LIVES_W : widths of the wall depth and per-player lives fields
//   in_goal_window() : true when a wall depth lies in the inclusive judge window
// ---------------------------------------------------------------------------
package game_pkg;

   localparam int DEPTH_W = 8;
   localparam int LIVES_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAYING   = 3'd2,
      ST_ROUND_END = 3'd3,
      ST_GAME_OVER = 3'd4
   } game_state_t;

   // Window is [goal-delta, goal+delta], both ends inclusive.
   function automatic logic in_goal_window(input logic [DEPTH_W-1:0] depth,
                                           input int goal,
                                           input int delta);
      int d;
      d = int'(depth);
      return (d >= goal - delta) && (d <= goal + delta);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen
// Counts frame pulses and emits a single-cycle tick on every period_in-th one.
// The tick is combinational with the frame pulse that completes the period,
// so the owner sees it in the same cycle as the closing frame.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   clear_in       : synchronous clear of the frame count (wins over frame_in)
//   frame_in       : one-cycle frame pulse
//   period_in      : frames per tick (must be >= 1)
//   tick_out       : one-cycle tick
// ---------------------------------------------------------------------------
module frame_tick_gen
   import game_pkg::*;
(
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               clear_in,
   input  logic               frame_in,
   input  logic [DEPTH_W-1:0] period_in,
   output logic               tick_out
);

   logic [DEPTH_W-1:0] count_q, count_d;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      tick_out = 1'b0;
      count_d  = count_q;
      if (clear_in) begin
         count_d = '0;
      end else if (frame_in) begin
         // >= rather than == keeps the counter from running away if the
         // period is ever lowered below the current count.
         if (count_q >= period_in - 1'b1) begin
            tick_out = 1'b1;
            count_d  = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/game_round_controller.sv
// ---------------------------------------------------------------------------
// game_round_controller
// Multi-player round sequencer: runs the game FSM, advances the wall depth at
// a per-round speed that ramps up, judges each player against the wall inside
// the goal-depth window with a per-frame pixel threshold, and tracks lives.
//   clk_in, rst_in                   : clock, asynchronous active-high reset
//   start_in                         : one-cycle start pulse (IDLE / GAME_OVER)
//   hcount_in, vcount_in, data_valid_in, is_wall_in, is_person_in : pixel stream
//   hcount_out, vcount_out, data_valid_out, is_wall_out, is_collision_out :
//                                      pixel stream and flags, 1-cycle latency
//   wall_depth_out                   : current wall depth
//   wall_idx_out, wall_load_out      : wall mask index and one-cycle load request
//   lives_out                        : packed lives, player 0 in the LSBs
//   round_out                        : rounds completed (saturating)
//   game_state_out                   : registered FSM state
// ---------------------------------------------------------------------------
module game_round_controller
   import game_pkg::*;
#(
   parameter int NUM_PLAYERS         = 2,
   parameter int SCREEN_WIDTH        = 1280,
   parameter int SCREEN_HEIGHT       = 720,
   parameter int GOAL_DEPTH          = 60,
   parameter int GOAL_DEPTH_DELTA    = 10,
   parameter int MAX_WALL_DEPTH      = 75,
   parameter int MAX_FRAMES_PER_TICK = 15,
   parameter int MIN_FRAMES_PER_TICK = 2,
   parameter int SPEEDUP_ROUNDS      = 3,
   parameter int COUNTDOWN_FRAMES    = 120,
   parameter int COLLISION_THRESHOLD = 64,
   parameter int START_LIVES         = 3,
   parameter int NUM_WALLS           = 10
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           start_in,
   input  logic [10:0]                    hcount_in,
   input  logic [9:0]                     vcount_in,
   input  logic                           data_valid_in,
   input  logic                           is_wall_in,
   input  logic [NUM_PLAYERS-1:0]         is_person_in,
   output logic [10:0]                    hcount_out,
   output logic [9:0]                     vcount_out,
   output logic                           data_valid_out,
   output logic                           is_wall_out,
   output logic [NUM_PLAYERS-1:0]         is_collision_out,
   output logic [DEPTH_W-1:0]             wall_depth_out,
   output logic [3:0]                     wall_idx_out,
   output logic                           wall_load_out,
   output logic [LIVES_W*NUM_PLAYERS-1:0] lives_out,
   output logic [7:0]                     round_out,
   output logic [2:0]                     game_state_out
);

   localparam logic [10:0]         H_LAST     = 11'(SCREEN_WIDTH - 1);
   localparam logic [9:0]          V_LAST     = 10'(SCREEN_HEIGHT - 1);
   localparam logic [DEPTH_W-1:0]  DEPTH_TOP  = DEPTH_W'(MAX_WALL_DEPTH - 1);
   localparam logic [DEPTH_W-1:0]  FPT_MAX    = DEPTH_W'(MAX_FRAMES_PER_TICK);
   localparam logic [DEPTH_W-1:0]  FPT_MIN    = DEPTH_W'(MIN_FRAMES_PER_TICK);
   localparam logic [DEPTH_W-1:0]  CD_FRAMES  = DEPTH_W'(COUNTDOWN_FRAMES);
   localparam logic [7:0]          SPEEDUP    = 8'(SPEEDUP_ROUNDS);
   localparam logic [3:0]          WIDX_LAST  = 4'(NUM_WALLS - 1);
   localparam logic [LIVES_W-1:0]  LIVES_INIT = LIVES_W'(START_LIVES);
   localparam int                  CNT_W      = ($clog2(COLLISION_THRESHOLD + 1) > 7) ?
                                                $clog2(COLLISION_THRESHOLD + 1) : 7;
   localparam logic [CNT_W-1:0]    CNT_THRESH = CNT_W'(COLLISION_THRESHOLD);

   typedef logic [NUM_PLAYERS-1:0][LIVES_W-1:0] lives_t;

   // ------------------------------------------------------------------
   // Pixel stream: plain 1-cycle pipeline, independent of game state.
   // ------------------------------------------------------------------
   logic                   new_frame;
   logic [NUM_PLAYERS-1:0] coll_pix;
   logic [10:0]            hcount_q;
   logic [9:0]             vcount_q;
   logic                   valid_q, wall_q;
   logic [NUM_PLAYERS-1:0] coll_q;

   assign new_frame = data_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
   assign coll_pix  = {NUM_PLAYERS{data_valid_in & is_wall_in}} & is_person_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hcount_q <= '0;
         vcount_q <= '0;
         valid_q  <= 1'b0;
         wall_q   <= 1'b0;
         coll_q   <= '0;
      end else begin
         hcount_q <= hcount_in;
         vcount_q <= vcount_in;
         valid_q  <= data_valid_in;
         wall_q   <= is_wall_in;
         coll_q   <= coll_pix;
      end
   end

   assign hcount_out       = hcount_q;
   assign vcount_out       = vcount_q;
   assign data_valid_out   = valid_q;
   assign is_wall_out      = wall_q;
   assign is_collision_out = coll_q;

   // ------------------------------------------------------------------
   // Game state registers
   // ------------------------------------------------------------------
   game_state_t            state_q, state_d;
   logic [DEPTH_W-1:0]     depth_q, depth_d;
   logic [DEPTH_W-1:0]     fpt_q, fpt_d;
   logic [7:0]             round_q, round_d;
   logic [3:0]             widx_q, widx_d;
   logic                   load_q, load_d;
   lives_t                 lives_q, lives_d;
   logic [NUM_PLAYERS-1:0] hit_q, hit_d;

   // One tick generator serves both the countdown and the wall speed; the
   // period is chosen by state and the count is held clear outside them.
   logic                   counting, tick;
   logic [DEPTH_W-1:0]     tick_period;

   assign counting    = (state_q == ST_COUNTDOWN) || (state_q == ST_PLAYING);
   assign tick_period = (state_q == ST_COUNTDOWN) ? CD_FRAMES : fpt_q;

   frame_tick_gen u_tick (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clear_in  (!counting),
      .frame_in  (new_frame && counting),
      .period_in (tick_period),
      .tick_out  (tick)
   );

   // ------------------------------------------------------------------
   // Per-player judging. Uses the registered (pre-tick) depth, so a frame
   // that closes with a tick into the window is judged at the old depth.
   // ------------------------------------------------------------------
   logic                   judge_active;
   logic [NUM_PLAYERS-1:0] hit_set;

   assign judge_active = (state_q == ST_PLAYING) &&
                         in_goal_window(depth_q, GOAL_DEPTH, GOAL_DEPTH_DELTA);

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_judge
      logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;

      // cnt_sum already includes the current pixel, so a collision on the
      // closing pixel counts toward that frame's threshold compare.
      always_comb begin
         cnt_sum = cnt_q;
         if (coll_pix[p] && (cnt_q != '1)) cnt_sum = cnt_q + 1'b1;
         cnt_d = (new_frame || !judge_active) ? '0 : cnt_sum;
      end

      assign hit_set[p] = new_frame && judge_active && (cnt_sum >= CNT_THRESH);

      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) cnt_q <= '0;
         else        cnt_q <= cnt_d;
      end
   end

   // Lives after this round's penalties, and whether everyone is out.
   lives_t     lives_after;
   logic       all_dead;
   logic [7:0] round_inc;

   always_comb begin
      lives_after = lives_q;
      all_dead    = 1'b1;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (hit_q[p] && (lives_q[p] != '0)) lives_after[p] = lives_q[p] - 1'b1;
         if (lives_after[p] != '0) all_dead = 1'b0;
      end
   end

   assign round_inc = (round_q == 8'hFF) ? round_q : round_q + 8'd1;

   // ------------------------------------------------------------------
   // FSM next state and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      depth_d = depth_q;
      fpt_d   = fpt_q;
      round_d = round_q;
      widx_d  = widx_q;
      load_d  = 1'b0;
      lives_d = lives_q;
      hit_d   = hit_q | hit_set;

      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start_in) begin
               lives_d = {NUM_PLAYERS{LIVES_INIT}};
               round_d = '0;
               fpt_d   = FPT_MAX;
               widx_d  = '0;
               hit_d   = '0;
               load_d  = 1'b1;
               state_d = ST_COUNTDOWN;
            end
         end
         ST_COUNTDOWN: begin
            if (tick) begin
               depth_d = '0;
               state_d = ST_PLAYING;
            end
         end
         ST_PLAYING: begin
            if (tick) begin
               // The tick that would reach MAX_WALL_DEPTH ends the round.
               if (depth_q == DEPTH_TOP) state_d = ST_ROUND_END;
               else                      depth_d = depth_q + 1'b1;
            end
         end
         ST_ROUND_END: begin
            lives_d = lives_after;
            hit_d   = '0;
            round_d = round_inc;
            widx_d  = (widx_q == WIDX_LAST) ? 4'd0 : widx_q + 4'd1;
            load_d  = 1'b1;
            if ((round_inc != 8'd0) && ((round_inc % SPEEDUP) == 8'd0))
               fpt_d = (fpt_q > FPT_MIN) ? fpt_q - 1'b1 : FPT_MIN;
            state_d = all_dead ? ST_GAME_OVER : ST_COUNTDOWN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         depth_q <= '0;
         fpt_q   <= FPT_MAX;
         round_q <= '0;
         widx_q  <= '0;
         load_q  <= 1'b0;
         lives_q <= '0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         fpt_q   <= fpt_d;
         round_q <= round_d;
         widx_q  <= widx_d;
         load_q  <= load_d;
         lives_q <= lives_d;
         hit_q   <= hit_d;
      end
   end

   assign wall_depth_out = depth_q;
   assign wall_idx_out   = widx_q;
   assign wall_load_out  = load_q;
   assign lives_out      = lives_q;
   assign round_out      = round_q;
   assign game_state_out = state_q;

endmodule

// File: doc/game_round_controller.md
# game_round_controller

Multi-player, round-based game sequencer that replaces the single-player wall controller in the pixel pipeline between the depth/segmentation stage and the renderer. It runs an explicit game state machine and advances the wall at a per-round speed that ramps up. It judges every player against the wall mask inside the goal-depth window using a per-frame pixel-count threshold, and tracks per-player lives. The wall mask itself is external: this block requests a new mask index each round and consumes a pixel-aligned `is_wall_in` bit.

## Interface
- `NUM_PLAYERS`, 2: number of independent person channels (1–4).
- `SCREEN_WIDTH`, 1280; `SCREEN_HEIGHT`, 720: active raster size.
- `GOAL_DEPTH`, 60; `GOAL_DEPTH_DELTA`, 10: judge window is `[GOAL_DEPTH-GOAL_DEPTH_DELTA, GOAL_DEPTH+GOAL_DEPTH_DELTA]`, inclusive.
- `MAX_WALL_DEPTH`, 75: depth at which a round ends.
- `MAX_FRAMES_PER_TICK`, 15; `MIN_FRAMES_PER_TICK`, 2: starting and floor wall speed.
- `SPEEDUP_ROUNDS`, 3: number of rounds between speed steps.
- `COUNTDOWN_FRAMES`, 120: frames spent in COUNTDOWN.
- `COLLISION_THRESHOLD`, 64: colliding pixels in one frame needed to count as a hit.
- `START_LIVES`, 3; `NUM_WALLS`, 10: lives per player and number of wall masks cycled.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `start_in` in 1: single-cycle start pulse (debounced upstream).
- `hcount_in` in 11, `vcount_in` in 10, `data_valid_in` in 1: pixel stream.
- `is_wall_in` in 1: wall mask bit for the current pixel.
- `is_person_in` in NUM_PLAYERS: person bit per player for the current pixel.
- `hcount_out` out 11, `vcount_out` out 10, `data_valid_out` out 1: stream delayed by 1 cycle.
- `is_wall_out` out 1; `is_collision_out` out NUM_PLAYERS: per-pixel flags, delayed by 1 cycle.
- `wall_depth_out` out 8: current wall depth.
- `wall_idx_out` out 4; `wall_load_out` out 1: mask index and a one-cycle request to load it.
- `lives_out` out 3·NUM_PLAYERS: packed lives, player 0 in the LSBs.
- `round_out` out 8: rounds completed, saturating at 255.
- `game_state_out` out 3: current FSM state encoding.

## Operation
- Definitions:
  - `new_frame` = `data_valid_in` && `hcount_in==SCREEN_WIDTH-1` && `vcount_in==SCREEN_HEIGHT-1`.
  - Per-pixel collision[p] = `data_valid_in` && `is_wall_in` && `is_person_in[p]`.
- FSM states: IDLE=0, COUNTDOWN=1, PLAYING=2, ROUND_END=3, GAME_OVER=4.
- IDLE:
  - `start_in` loads lives=START_LIVES for every player, round=0, frames_per_tick=MAX_FRAMES_PER_TICK, wall_idx=0.
  - Pulses `wall_load_out`, then goes to COUNTDOWN.
- COUNTDOWN:
  - Counts `new_frame`s.
  - After COUNTDOWN_FRAMES frames, goes to PLAYING with depth=0 and the tick counter cleared.
- PLAYING:
  - Every frames_per_tick `new_frame`s, depth increments by 1.
  - The tick that would make depth equal MAX_WALL_DEPTH goes to ROUND_END instead; depth holds at MAX_WALL_DEPTH-1.
- Judging (only while PLAYING and depth is inside the window):
  - Per player, a per-frame collision counter (saturating, ≥7 bits) increments on each collision pixel.
  - On `new_frame`, if count ≥ COLLISION_THRESHOLD, set hit[p]. Counters clear on every `new_frame`.
  - hit[] is sticky for the rest of the round.
- ROUND_END (exactly one cycle):
  - Every player with hit set loses one life, saturating at 0. hit[] clears.
  - round increments (saturating). wall_idx advances and wraps from NUM_WALLS-1 to 0. `wall_load_out` pulses.
  - If round (after increment) is a nonzero multiple of SPEEDUP_ROUNDS, frames_per_tick decrements, floored at MIN_FRAMES_PER_TICK.
  - Next state: GAME_OVER if every player's lives are now 0, else COUNTDOWN.
- GAME_OVER:
  - Holds all counters.
  - `start_in` restarts exactly as from IDLE.
- Players already at 0 lives are still judged, but their lives stay 0.
- `start_in` is ignored in COUNTDOWN, PLAYING and ROUND_END.

## Timing
- Pixel outputs (`*_out` stream, `is_wall_out`, `is_collision_out`) are registered with a latency of 1 cycle and are independent of FSM state.
- State, depth, lives and round update on the clock edge after the causing event. `game_state_out` is registered.
- When a collision pixel and `new_frame` occur in the same cycle, the pixel counts toward the closing frame before the threshold compare.
- When a wall tick and entry into the judge window occur on the same `new_frame`, judging of the frame just closed uses the pre-tick depth.
- Reset values:
  - State IDLE; depth 0; lives 0; round 0; wall_idx 0.
  - `wall_load_out` 0; all pixel outputs 0; frames_per_tick MAX_FRAMES_PER_TICK.
- Reset asserted mid-round returns everything to the reset values immediately (asynchronously); no load pulse is issued.

## Structure
- Package `game_pkg`:
  - `game_state_t` enum (3-bit, encodings above).
  - Depth width constant (8) and lives width constant (3).
  - Helper function `in_goal_window(depth)`.
- Sub-module `frame_tick_gen`:
  - Counts `new_frame`, configurable period input, synchronous clear.
  - Emits a single-cycle tick.
  - Instantiated once for wall ticks and reused for countdown.
- Per-player judge logic is a generate loop within the top module.

## Test plan
- Reset, then `start_in` → `game_state_out` 0→1, lives_out all 3, one `wall_load_out` pulse with `wall_idx_out`=0; after 120 frames, state=2.
- No person pixels for a full round → depth reaches 74, state passes through 3 for one cycle, lives unchanged, round=1, `wall_idx_out`=1.
- Player 1 has 64 collision pixels in one frame at depth 55 → player 1 lives 3→2 at ROUND_END, player 0 unchanged. 63 pixels in every frame → no life lost.
- Collisions only at depth 49 and 71 → no hit (window edges are exclusive outside 50..70).
- Speed ramp: play 3 rounds → frames_per_tick 15→14, observed as a tick period of 14 frames. Long run floors at 2.
- Both players hit every round → GAME_OVER after round 3, then `start_in` restarts with lives 3. Asserting `rst_in` mid-PLAYING → state 0, depth 0 the same cycle.
